// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter/sequencer for a shared multi-cycle multiplier.
// Optional WAIT timeout is built when MUL_ARB_TIMEOUT_EN is defined.
module mul_arbiter #(
  parameter int W       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  output logic [2*W-1:0] rsp0_data,
  output logic           rsp0_err,
  output logic           rsp1_valid,
  output logic [2*W-1:0] rsp1_data,
  output logic           rsp1_err,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_result,
  output logic           busy,
  output logic           owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           owner_q, owner_d;
  logic           busy_q, busy_d;
  logic           start_q, start_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           v0_q, v0_d;
  logic           v1_q, v1_d;
  logic [2*W-1:0] d0_q, d0_d;
  logic [2*W-1:0] d1_q, d1_d;
  logic           e0_q, e0_d;
  logic           e1_q, e1_d;

  logic           win1;
  logic           hs;
  logic           tmo;
  logic [2*W-1:0] res;
  logic           err;

  // port 1 wins when alone, or on contention when it holds priority
  assign win1       = req1_valid & (~req0_valid | prio_q);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~win1;
  assign req1_ready = (state_q == IDLE) & win1;
  assign hs         = req0_ready | req1_ready;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  // count WAIT cycles; cleared while issuing so WAIT starts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    start_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    v0_d    = 1'b0;
    v1_d    = 1'b0;
    d0_d    = d0_q;
    d1_d    = d1_q;
    e0_d    = 1'b0;
    e1_d    = 1'b0;
    res     = mul_done ? mul_result : '0;
    err     = ~mul_done;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ISSUE;
          owner_d = req1_ready;
          start_d = 1'b1;
          a_d     = req1_ready ? req1_a : req0_a;
          b_d     = req1_ready ? req1_b : req0_b;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done || tmo) begin
          state_d = RESP;
          unique case (1'b1)
            owner_q: begin
              v1_d = 1'b1;
              d1_d = res;
              e1_d = err;
            end
            default: begin
              v0_d = 1'b1;
              d0_d = res;
              e0_d = err;
            end
          endcase
        end
      end
      RESP: begin
        state_d = IDLE;
        prio_d  = ~owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      e0_q    <= 1'b0;
      e1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign mul_start  = start_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign rsp0_valid = v0_q;
  assign rsp1_valid = v1_q;
  assign rsp0_data  = d0_q;
  assign rsp1_data  = d1_q;
  assign rsp0_err   = e0_q;
  assign rsp1_err   = e1_q;

endmodule
